// File: rtl/rca_pipe_nbits.sv
// Pipelined ripple-carry adder: n bits split into `stages` slices with a registered carry between slices, valid/ready handshake.
// Define RCA_PIPE_OVF_EN to add the registered signed-overflow output `ovf`.
module rca_pipe_nbits #(
  parameter int n      = 32,
  parameter int stages = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] s,
  output logic         cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W    = (stages > 0) ? n / stages : n;
  localparam int LAST = stages - 1;

  if (stages < 1 || stages > n || (n % stages) != 0) begin : g_bad_cfg
    $error("rca_pipe_nbits: stages must be in 1..n and divide n");
  end

  // acc_q[k] holds the staircase {x bits not yet added, sum bits so far};
  // y_q[k] holds the not-yet-added y bits, right-justified.
  logic         v_q   [stages];
  logic         c_q   [stages];
  logic [n-1:0] acc_q [stages];
  logic [n-1:0] y_q   [stages];
  logic         adv;

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q;
`endif

  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < stages; k++) begin : g_st
    logic [n-1:0] a_src;
    logic [n-1:0] b_src;
    logic         c_src;
    logic         v_src;
    logic [W:0]   sum;
    logic [n-1:0] a_nxt;

    if (k == 0) begin : g_first
      assign a_src = x;
      assign b_src = y;
      assign c_src = cin;
      assign v_src = in_valid;
    end else begin : g_next
      assign a_src = acc_q[k-1];
      assign b_src = y_q[k-1];
      assign c_src = c_q[k-1];
      assign v_src = v_q[k-1];
    end

    assign sum = {1'b0, a_src[k*W +: W]} + {1'b0, b_src[W-1:0]} + {{W{1'b0}}, c_src};

    always_comb begin
      a_nxt            = a_src;
      a_nxt[k*W +: W]  = sum[W-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        acc_q[k] <= '0;
        y_q[k]   <= '0;
      end else if (adv) begin
        v_q[k]   <= v_src;
        c_q[k]   <= sum[W];
        acc_q[k] <= a_nxt;
        y_q[k]   <= b_src >> W;
      end
    end

`ifdef RCA_PIPE_OVF_EN
    if (k == LAST) begin : g_ovf
      // Carry into the MSB is recovered as s^x^y at bit n-1, then XORed with the carry out.
      logic cmsb;
      assign cmsb = a_src[n-1] ^ b_src[W-1] ^ sum[W-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cmsb ^ sum[W];
        end
      end
    end
`endif
  end

  assign out_valid = v_q[LAST];
  assign s         = acc_q[LAST];
  assign cout      = c_q[LAST];

`ifdef RCA_PIPE_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule
